// File: rtl/seg_scan_if.sv
// Bus between the BCD counter chain and the 7-segment scanner: digit data in, display pins out.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    lz_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits, dp_mask, lz_en,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  digits, dp_mask, lz_en,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scanner: frame-coherent snapshot, anti-ghost blanking,
// leading-zero suppression and dash display for non-BCD codes. All outputs registered.
module seg_scan #(
  parameter int unsigned CLOCKSPEED   = 50000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int unsigned Dwell = CLOCKSPEED / REFRESH_HZ;
  localparam int unsigned PW    = (Dwell > 1) ? $clog2(Dwell) : 1;
  localparam int unsigned IW    = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0]         PrescLast = PW'(Dwell - 1);
  localparam logic [PW-1:0]         BlankEnd  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IdxLast   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SegPol    = COMMON_ANODE ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AnPol     = COMMON_ANODE ? '1 : '0;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_lz_q, snap_lz_d;
  logic                    frame_q, frame_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick, wrap;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              nib;
  logic [6:0]              seg_hi;
  logic [NUM_DIGITS-1:0]   an_hi;

  // Prescaler, scan index and snapshot; the snapshot only moves on the frame wrap.
  always_comb begin
    tick       = (presc_q == PrescLast);
    wrap       = tick && (idx_q == IdxLast);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    frame_d    = wrap;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    if (wrap) begin
      snap_dig_d = bus.digits;
      snap_dp_d  = bus.dp_mask;
      snap_lz_d  = bus.lz_en;
    end
  end

  // Digit k is a leading zero if it and every more significant digit are zero.
  always_comb begin
    blank    = '0;
    zero_run = snap_lz_q;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (snap_dig_q[4*k +: 4] == 4'd0);
      blank[k] = zero_run & ~snap_dp_q[k];
    end
  end

  always_comb begin
    nib = snap_dig_q[4*idx_q +: 4];
    case (nib)
      4'd0:    seg_hi = 7'b0111111;
      4'd1:    seg_hi = 7'b0000110;
      4'd2:    seg_hi = 7'b1011011;
      4'd3:    seg_hi = 7'b1001111;
      4'd4:    seg_hi = 7'b1100110;
      4'd5:    seg_hi = 7'b1101101;
      4'd6:    seg_hi = 7'b1111101;
      4'd7:    seg_hi = 7'b0000111;
      4'd8:    seg_hi = 7'b1111111;
      4'd9:    seg_hi = 7'b1101111;
      default: seg_hi = 7'b1000000;
    endcase
    an_hi = '0;
    if ((presc_q >= BlankEnd) && !blank[idx_q]) begin
      an_hi = NUM_DIGITS'(1) << idx_q;
    end
    seg_d = (blank[idx_q] ? 7'b0000000 : seg_hi) ^ SegPol;
    an_d  = an_hi ^ AnPol;
    dp_d  = snap_dp_q[idx_q] ^ COMMON_ANODE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= SegPol;
      an_q       <= AnPol;
      dp_q       <= COMMON_ANODE;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: common-anode and common-cathode instances share stimulus and are
// checked every cycle against a frame/dwell arithmetic model plus hand-computed points.
module tb_seg_scan;

  localparam int Nd    = 4;
  localparam int Dwell = 8;
  localparam int Frame = Dwell * Nd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        lz_en;

  seg_scan_if #(.NUM_DIGITS(Nd)) bus_ca ();
  seg_scan_if #(.NUM_DIGITS(Nd)) bus_cc ();

  assign bus_ca.digits  = digits;
  assign bus_ca.dp_mask = dp_mask;
  assign bus_ca.lz_en   = lz_en;
  assign bus_cc.digits  = digits;
  assign bus_cc.dp_mask = dp_mask;
  assign bus_cc.lz_en   = lz_en;

  seg_scan #(
    .CLOCKSPEED  (8000),
    .REFRESH_HZ  (1000),
    .NUM_DIGITS  (Nd),
    .BLANK_CYCLES(2),
    .COMMON_ANODE(1'b1)
  ) u_ca (
    .clk(clk),
    .rst(rst),
    .bus(bus_ca)
  );

  seg_scan #(
    .CLOCKSPEED  (8000),
    .REFRESH_HZ  (1000),
    .NUM_DIGITS  (Nd),
    .BLANK_CYCLES(2),
    .COMMON_ANODE(1'b0)
  ) u_cc (
    .clk(clk),
    .rst(rst),
    .bus(bus_cc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: n = rising edges since reset release; frame f's snapshot is the input at edge f*Frame.
  int          n = 0;
  logic [15:0] fr_dig [0:15];
  logic [3:0]  fr_dp  [0:15];
  logic        fr_lz  [0:15];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n         <= 0;
      fr_dig[0] <= 16'h0;
      fr_dp[0]  <= 4'h0;
      fr_lz[0]  <= 1'b0;
    end else begin
      n <= n + 1;
      if ((n + 1) % Frame == 0) begin
        fr_dig[((n + 1) / Frame) % 16] <= digits;
        fr_dp[((n + 1) / Frame) % 16]  <= dp_mask;
        fr_lz[((n + 1) / Frame) % 16]  <= lz_en;
      end
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Active-high {frame_start, dp, an[3:0], seg[6:0]} visible after cnt edges.
  function automatic logic [12:0] expect_hi(input int cnt);
    int          s, p, i, f;
    logic [15:0] dig;
    logic [3:0]  dpm;
    logic        blank, fs;
    logic [6:0]  sg;
    logic [3:0]  an;
    if (cnt == 0) return 13'h0;
    s     = cnt - 1;
    p     = s % Dwell;
    i     = (s / Dwell) % Nd;
    f     = (s / Frame) % 16;
    dig   = fr_dig[f];
    dpm   = fr_dp[f];
    fs    = (cnt % Frame == 0);
    blank = fr_lz[f] && (i != 0) && ((dig >> (4 * i)) == 16'h0) && !dpm[i];
    sg    = blank ? 7'h00 : decode(4'((dig >> (4 * i)) & 16'hF));
    an    = (!blank && p >= 2) ? (4'b0001 << i) : 4'b0000;
    return {fs, dpm[i], an, sg};
  endfunction

  logic chk_en = 1'b1;

  always @(negedge clk) begin
    logic [12:0] e, a_cc, a_ca;
    if (chk_en) begin
      e    = expect_hi(n);
      a_cc = {bus_cc.frame_start, bus_cc.dp, bus_cc.an, bus_cc.seg};
      a_ca = {bus_ca.frame_start, bus_ca.dp, bus_ca.an, bus_ca.seg};
      n_cmp++;
      if (a_cc !== e) begin
        n_bad++;
        $display("FAIL cc_model n=%0d got {fs,dp,an,seg}=%b expected %b", n, a_cc, e);
      end
      n_cmp++;
      if (a_ca !== (e ^ 13'h0FFF)) begin
        n_bad++;
        $display("FAIL ca_model n=%0d got {fs,dp,an,seg}=%b expected %b", n, a_ca,
                 e ^ 13'h0FFF);
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d got %b expected %b", name, n, act, exp);
    end
  endtask

  task automatic wait_n(input int k);
    int guard = 0;
    while (n != k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (n != k) begin
      n_bad++;
      $display("FAIL wait_n got n=%0d expected %0d", n, k);
    end
  endtask

  initial begin
    digits  = 16'h1234;
    dp_mask = 4'b0000;
    lz_en   = 1'b0;
    rst     = 1'b0;
    repeat (5) @(negedge clk);
    lit("reset_ca_an", 16'(bus_ca.an), 16'hF);
    lit("reset_ca_seg", 16'(bus_ca.seg), 16'h7F);
    lit("reset_ca_dp", 16'(bus_ca.dp), 16'h1);
    lit("reset_cc_an", 16'(bus_cc.an), 16'h0);
    rst = 1'b1;

    // Reset release and first frame (snapshot still zero).
    wait_n(1);  lit("f0_ca_an_blank", 16'(bus_ca.an), 16'b1111);
    wait_n(3);  lit("f0_ca_an_d0", 16'(bus_ca.an), 16'b1110);
                lit("f0_cc_seg_zero", 16'(bus_cc.seg), 16'b0111111);
    wait_n(8);  lit("f0_ca_an_d0_end", 16'(bus_ca.an), 16'b1110);
    wait_n(9);  lit("f0_ca_an_d1_blank", 16'(bus_ca.an), 16'b1111);
    wait_n(11); lit("f0_ca_an_d1", 16'(bus_ca.an), 16'b1101);
    wait_n(27); lit("f0_ca_an_d3", 16'(bus_ca.an), 16'b0111);
    wait_n(32); lit("frame_start_hi", 16'(bus_cc.frame_start), 16'h1);
    wait_n(33); lit("frame_start_lo", 16'(bus_cc.frame_start), 16'h0);

    // Decode sweep of 1234.
    wait_n(35); lit("sweep_d0", 16'(bus_cc.seg), 16'b1100110);
    wait_n(43); lit("sweep_d1", 16'(bus_cc.seg), 16'b1001111);
    wait_n(44); digits = 16'h0050; lz_en = 1'b1;
    wait_n(51); lit("sweep_d2", 16'(bus_cc.seg), 16'b1011011);
    wait_n(59); lit("sweep_d3", 16'(bus_cc.seg), 16'b0000110);

    // Leading-zero blanking of 0050.
    wait_n(67); lit("lz_d0_seg", 16'(bus_cc.seg), 16'b0111111);
                lit("lz_d0_an", 16'(bus_cc.an), 16'b0001);
    wait_n(70); dp_mask = 4'b0100;
    wait_n(75); lit("lz_d1_seg", 16'(bus_cc.seg), 16'b1101101);
    wait_n(83); lit("lz_d2_an", 16'(bus_cc.an), 16'b0000);
                lit("lz_d2_seg", 16'(bus_cc.seg), 16'b0000000);
    wait_n(91); lit("lz_d3_an", 16'(bus_cc.an), 16'b0000);
    wait_n(115); lit("dp_d2_an", 16'(bus_cc.an), 16'b0100);
                 lit("dp_d2_seg", 16'(bus_cc.seg), 16'b0111111);
                 lit("dp_d2_dp", 16'(bus_cc.dp), 16'h1);
    wait_n(120); digits = 16'h00A0; dp_mask = 4'b0000;
    wait_n(123); lit("dp_d3_an", 16'(bus_cc.an), 16'b0000);

    // Invalid code and tear-free snapshot.
    wait_n(139); lit("inv_d1_seg", 16'(bus_cc.seg), 16'b1000000);
                 lit("inv_d1_an", 16'(bus_cc.an), 16'b0010);
    wait_n(147); digits = 16'h9999;
                 lit("inv_d2_an", 16'(bus_cc.an), 16'b0000);
    wait_n(155); lit("inv_d3_seg", 16'(bus_cc.seg), 16'b0000000);
    wait_n(163); lit("nine_d0", 16'(bus_cc.seg), 16'b1101111);
    wait_n(187); lit("nine_d3_seg", 16'(bus_cc.seg), 16'b1101111);
                 lit("nine_d3_an", 16'(bus_cc.an), 16'b1000);

    // Asynchronous reset between edges at prescaler=5, idx=2.
    wait_n(213); lit("pre_rst_cc_an", 16'(bus_cc.an), 16'b0100);
    #1 rst = 1'b0;
    #1;
    lit("async_ca_an", 16'(bus_ca.an), 16'hF);
    lit("async_ca_seg", 16'(bus_ca.seg), 16'h7F);
    lit("async_ca_dp", 16'(bus_ca.dp), 16'h1);
    lit("async_cc_an", 16'(bus_cc.an), 16'h0);
    lit("async_cc_seg", 16'(bus_cc.seg), 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_n(1); lit("restart_cc_an_blank", 16'(bus_cc.an), 16'b0000);
    wait_n(3); lit("restart_cc_an_d0", 16'(bus_cc.an), 16'b0001);
               lit("restart_cc_seg_zero", 16'(bus_cc.seg), 16'b0111111);
               lit("restart_ca_an_d0", 16'(bus_ca.an), 16'b1110);
    wait_n(40);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Downstream consumer of the cascaded BCD digit counters.
- Takes NUM_DIGITS packed 4-bit BCD digits and time-multiplexes them onto one shared 7-segment bus plus per-digit enables.
- Provides refresh prescaling, frame-coherent digit snapshot, anti-ghost blanking, leading-zero suppression and invalid-code display.
- Sits between the counter chain and board pins.

Parameters:
- CLOCKSPEED, 50000000, input clock frequency in Hz.
- REFRESH_HZ, 1000, digit-switch rate in Hz. DWELL = CLOCKSPEED/REFRESH_HZ clocks per digit; DWELL must be ≥ BLANK_CYCLES+2.
- NUM_DIGITS, 4, number of digits scanned (2..8).
- BLANK_CYCLES, 2, clocks at the start of each dwell with all digits disabled.
- COMMON_ANODE, 1, 1 = seg/dp/an outputs active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- digits  input  4*NUM_DIGITS  BCD digits; digits[3:0] is the least significant digit (index 0).
- dp_mask  input  NUM_DIGITS  decimal point request per digit index.
- lz_en  input  1  1 = leading-zero blanking enabled.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point for the active digit.
- an  output  NUM_DIGITS  digit enables, one-hot when active.
- frame_start  output  1  one-clock pulse when the scan index wraps to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler=0, idx=0, snapshot=0.
  - an, seg and dp all at their inactive level: all 1s if COMMON_ANODE=1, all 0s otherwise.
  - frame_start=0.
  - State held until the clock edge after rst deasserts.
- Prescaler:
  - Counts 0..DWELL-1 and wraps.
  - tick is asserted when the prescaler equals DWELL-1.
- Scan index:
  - On tick, idx advances idx+1; NUM_DIGITS-1 wraps to 0.
  - When idx wraps to 0, the snapshot register loads `digits` and dp_mask in that same edge, and frame_start pulses high for exactly one clock, registered and aligned with the first cycle of idx=0.
  - Input changes mid-frame are not visible until the next frame.
  - First frame after reset shows the snapshot value 0.
- Blanking window:
  - While prescaler < BLANK_CYCLES, an is all inactive.
  - From that point to the end of the dwell, an has only bit idx active.
  - seg/dp are updated to the new digit during the blank window.
- Decode of the selected snapshot nibble:
  - 0..9: standard patterns. Active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - 10..15: dash, 1000000.
- Leading-zero blanking (lz_en=1):
  - Digit k is blanked (seg all off, an stays inactive for the whole dwell) when snapshot digits k..NUM_DIGITS-1 are all 0 and k≠0.
  - Digit 0 is never blanked.
  - dp_mask[k]=1 overrides blanking for digit k: digit shown as 0 with dp.
  - Invalid codes count as non-zero.
  - lz_en is sampled with the snapshot.
- Timing and polarity:
  - All outputs are registered.
  - seg/an/dp reflect idx one clock after idx updates.
  - Polarity inversion is applied at the output register only.
- Power-on behaviour: no combinational paths from inputs to outputs.

Test Plan:
1. Reset and first frame:
   - Stimulus: CLOCKSPEED=8000, REFRESH_HZ=1000 (DWELL=8), COMMON_ANODE=1. Hold rst=0 for 5 clocks, then release.
   - Response: an=1111, seg=1111111, dp=1 throughout reset. After release, an cycles 1110,1101,1011,0111, each low for 6 of 8 clocks. frame_start pulses every 32 clocks.
2. Decode sweep:
   - Stimulus: COMMON_ANODE=0, lz_en=0, digits=16'h1234 held 2 frames.
   - Response: during idx0 seg=1100110; idx1 1001111; idx2 1011011; idx3 0000110. Snapshot visible only from the second frame.
3. Leading-zero blanking:
   - Stimulus: digits=16'h0050, lz_en=1, dp_mask=0.
   - Response: idx3 blanked (an inactive all dwell); idx2 blanked; idx1 shows 5; idx0 shows 0.
   - Follow-up: with dp_mask=4'b0100, idx2 shows 0 with dp active.
4. Invalid codes and tear-free snapshot:
   - Stimulus: digits=16'h00A0, with digits changed to 16'h9999 mid-frame at idx=2.
   - Response: the current frame still shows dash on idx1 (seg=1000000) and blanks idx2/idx3. The next frame shows 9 on all digits.
5. Async reset mid-dwell:
   - Stimulus: assert rst=0 at prescaler=5, idx=2, between clock edges.
   - Response: outputs go inactive immediately, without a clock edge. After release, scanning restarts at idx0 with prescaler=0.
